// File: rtl/exc_ctrl_if.sv
// Decoder/CP0-facing signal bundle of the exception controller.
// master = decoder/CP0 side, slave = exc_ctrl.
interface exc_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic               syscall_i;
  logic               break_i;
  logic               teq_i;
  logic               eret_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic [31:0]        status_i;
  logic               exc_o;
  logic [4:0]         cause_o;
  logic               eret_o;
  logic [1:0]         pc_sel_o;
  logic               squash_o;
  logic               in_handler_o;
  logic [NUM_IRQ-1:0] irq_pending_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic               err_o;

  modport master (
    output syscall_i, break_i, teq_i, eret_i, irq_i, status_i,
    input  exc_o, cause_o, eret_o, pc_sel_o, squash_o, in_handler_o,
           irq_pending_o, irq_ack_o, err_o
  );

  modport slave (
    input  syscall_i, break_i, teq_i, eret_i, irq_i, status_i,
    output exc_o, cause_o, eret_o, pc_sel_o, squash_o, in_handler_o,
           irq_pending_o, irq_ack_o, err_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitrates traps and external IRQs against
// CP0 Status, sequences handler entry/ERET, and drives CP0 and the PC mux.
module exc_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] HANDLER_VEC = 32'h0040_0004
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HANDLER = 2'd1, COOLDOWN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               err_q, err_d;

  logic [NUM_IRQ-1:0] irq_edge, irq_win, ack;
  logic               ie, take_teq, take_brk, take_sys, take_irq;
  logic               exc, eret;
  logic [4:0]         cause;
  logic [1:0]         pc_sel;

  // The handler address is applied by the PC mux when pc_sel_o == 1.
  logic unused;
  assign unused = ^{bus.status_i[31:5], HANDLER_VEC};

  assign irq_edge = sync2_q & ~prev_q;
  // Isolate the lowest set pending bit: lowest index wins.
  assign irq_win  = pending_q & ((~pending_q) + NUM_IRQ'(1));

  assign ie       = bus.status_i[0];
  assign take_teq = bus.teq_i     & ie & bus.status_i[3];
  assign take_brk = bus.break_i   & ie & bus.status_i[2];
  assign take_sys = bus.syscall_i & ie & bus.status_i[1];
  assign take_irq = ie & bus.status_i[4] & (|pending_q);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    exc     = 1'b0;
    eret    = 1'b0;
    cause   = 5'd0;
    pc_sel  = 2'd0;
    ack     = '0;
    case (state_q)
      IDLE, COOLDOWN: begin
        if (take_teq) begin
          exc = 1'b1; cause = 5'd13;
        end else if (take_brk) begin
          exc = 1'b1; cause = 5'd9;
        end else if (take_sys) begin
          exc = 1'b1; cause = 5'd8;
        end else if (state_q == IDLE && take_irq) begin
          // COOLDOWN blocks interrupts so the instruction at EPC runs first.
          exc = 1'b1; cause = 5'd0; ack = irq_win;
        end
        if (exc) begin
          pc_sel  = 2'd1;
          state_d = HANDLER;
        end else if (state_q == COOLDOWN) begin
          state_d = IDLE;
        end
        if (bus.eret_i) err_d = 1'b1;
      end
      HANDLER: begin
        if (bus.syscall_i || bus.break_i || bus.teq_i) err_d = 1'b1;
        if (bus.eret_i) begin
          eret    = 1'b1;
          pc_sel  = 2'd2;
          state_d = COOLDOWN;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the line being acked wins over the clear.
    pending_d = (pending_q & ~ack) | irq_edge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus.irq_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.exc_o         = exc;
  assign bus.cause_o       = cause;
  assign bus.eret_o        = eret;
  assign bus.pc_sel_o      = pc_sel;
  assign bus.squash_o      = exc;
  assign bus.in_handler_o  = (state_q == HANDLER);
  assign bus.irq_pending_o = pending_q;
  assign bus.irq_ack_o     = ack;
  assign bus.err_o         = err_q;
endmodule
